// File: rtl/render_pkg.sv
// Shared state encoding and per-frame clear defaults for the framebuffer render scheduler.
package render_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_START  = 3'd2,
        ST_RASTER = 3'd3,
        ST_DRAIN  = 3'd4
    } render_state_t;

    localparam int FB_CLEAR_DEFAULT = 0;
    localparam int DB_CLEAR_DEFAULT = 4095;

endpackage

// File: rtl/depth_test_pipe.sv
// Depth test for accepted fragments: read issued on accept, compare/write one cycle later,
// back-to-back same-address hazard forwarded. FB_RENDER_DEPTH_TEST_EN enables the test.
module depth_test_pipe #(
    parameter int ADDRW    = 15,
    parameter int FB_DATAW = 4,
    parameter int DB_DATAW = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                accept_en,
    input  logic                rast_valid,
    input  logic [ADDRW-1:0]    rast_addr,
    input  logic [FB_DATAW-1:0] rast_color,
    input  logic [DB_DATAW-1:0] rast_depth,
    output logic [ADDRW-1:0]    db_rd_addr,
    input  logic [DB_DATAW-1:0] db_rd_data,
    output logic                wr_vld,
    output logic [ADDRW-1:0]    wr_addr,
    output logic [FB_DATAW-1:0] wr_color,
    output logic [DB_DATAW-1:0] wr_depth
);

    logic                accept;
    logic                p_vld;
    logic [ADDRW-1:0]    p_addr;
    logic [FB_DATAW-1:0] p_color;
    logic [DB_DATAW-1:0] p_depth;
    logic                pass;

    assign accept = rast_valid && accept_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_vld   <= 1'b0;
            p_addr  <= '0;
            p_color <= '0;
            p_depth <= '0;
        end else begin
            p_vld <= accept;
            if (accept) begin
                p_addr  <= rast_addr;
                p_color <= rast_color;
                p_depth <= rast_depth;
            end
        end
    end

`ifdef FB_RENDER_DEPTH_TEST_EN
    logic                w_vld;
    logic [ADDRW-1:0]    w_addr;
    logic [DB_DATAW-1:0] w_depth;
    logic [DB_DATAW-1:0] stored_depth;

    // The memory read for this fragment raced the previous write; take that write's depth instead.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_vld   <= 1'b0;
            w_addr  <= '0;
            w_depth <= '0;
        end else begin
            w_vld   <= wr_vld;
            w_addr  <= p_addr;
            w_depth <= p_depth;
        end
    end

    assign stored_depth = (w_vld && (w_addr == p_addr)) ? w_depth : db_rd_data;
    assign pass         = p_depth < stored_depth;
    assign db_rd_addr   = accept ? rast_addr : '0;
`else
    logic unused_rd_data;
    assign unused_rd_data = ^db_rd_data;
    assign pass           = 1'b1;
    assign db_rd_addr     = '0;
`endif

    assign wr_vld   = p_vld && pass;
    assign wr_addr  = wr_vld ? p_addr  : '0;
    assign wr_color = wr_vld ? p_color : '0;
    assign wr_depth = wr_vld ? p_depth : '0;

endmodule

// File: rtl/fb_render_scheduler.sv
// Frame sequencer: clear fb/db one pixel per cycle, kick the rasteriser, depth-test fragments
// at one per cycle (write 1 cycle after accept), pulse frame_done. Macro: FB_RENDER_DEPTH_TEST_EN.
module fb_render_scheduler
    import render_pkg::*;
#(
    parameter int FB_WIDTH       = 160,
    parameter int FB_HEIGHT      = 120,
    parameter int FB_DATAW       = 4,
    parameter int DB_DATAW       = 12,
    parameter int FB_CLEAR_VALUE = FB_CLEAR_DEFAULT,
    parameter int DB_CLEAR_VALUE = DB_CLEAR_DEFAULT,
    localparam int FB_ADDRW      = $clog2(FB_WIDTH*FB_HEIGHT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start,
    output logic                busy,
    output logic                frame_done,
    output logic                rast_start,
    input  logic                rast_done,
    input  logic                rast_valid,
    output logic                rast_ready,
    input  logic [FB_ADDRW-1:0] rast_addr,
    input  logic [FB_DATAW-1:0] rast_color,
    input  logic [DB_DATAW-1:0] rast_depth,
    output logic                fb_we,
    output logic [FB_ADDRW-1:0] fb_addr,
    output logic [FB_DATAW-1:0] fb_data,
    output logic                db_we,
    output logic [FB_ADDRW-1:0] db_addr,
    output logic [DB_DATAW-1:0] db_data,
    output logic [FB_ADDRW-1:0] db_rd_addr,
    input  logic [DB_DATAW-1:0] db_rd_data
);

    localparam logic [FB_ADDRW-1:0] LAST_ADDR = FB_ADDRW'(FB_WIDTH*FB_HEIGHT - 1);
    localparam logic [FB_DATAW-1:0] FB_CLR    = FB_DATAW'(FB_CLEAR_VALUE);
    localparam logic [DB_DATAW-1:0] DB_CLR    = DB_DATAW'(DB_CLEAR_VALUE);

    render_state_t       state;
    render_state_t       state_nxt;
    logic [FB_ADDRW-1:0] clr_cnt;
    logic                accept;

    logic                pipe_wr_vld;
    logic [FB_ADDRW-1:0] pipe_wr_addr;
    logic [FB_DATAW-1:0] pipe_wr_color;
    logic [DB_DATAW-1:0] pipe_wr_depth;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end else begin
                clr_cnt <= '0;
            end
        end
    end

    assign accept = rast_valid && (state == ST_RASTER);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (frame_start) state_nxt = ST_CLEAR;
            ST_CLEAR:  if (clr_cnt == LAST_ADDR) state_nxt = ST_START;
            ST_START:  state_nxt = ST_RASTER;
            // A fragment arriving with rast_done still gets accepted; the drain waits a cycle.
            ST_RASTER: if (rast_done && !accept) state_nxt = ST_DRAIN;
            ST_DRAIN:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        rast_start = (state == ST_START);
        rast_ready = (state == ST_RASTER);
        frame_done = (state == ST_DRAIN);
        fb_we      = pipe_wr_vld;
        db_we      = pipe_wr_vld;
        fb_addr    = pipe_wr_addr;
        db_addr    = pipe_wr_addr;
        fb_data    = pipe_wr_color;
        db_data    = pipe_wr_depth;
        if (state == ST_CLEAR) begin
            fb_we   = 1'b1;
            db_we   = 1'b1;
            fb_addr = clr_cnt;
            db_addr = clr_cnt;
            fb_data = FB_CLR;
            db_data = DB_CLR;
        end
    end

    depth_test_pipe #(
        .ADDRW    (FB_ADDRW),
        .FB_DATAW (FB_DATAW),
        .DB_DATAW (DB_DATAW)
    ) u_depth_test_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept_en  (rast_ready),
        .rast_valid (rast_valid),
        .rast_addr  (rast_addr),
        .rast_color (rast_color),
        .rast_depth (rast_depth),
        .db_rd_addr (db_rd_addr),
        .db_rd_data (db_rd_data),
        .wr_vld     (pipe_wr_vld),
        .wr_addr    (pipe_wr_addr),
        .wr_color   (pipe_wr_color),
        .wr_depth   (pipe_wr_depth)
    );

endmodule

// File: tb/tb_fb_render_scheduler.sv
// Directed bench for fb_render_scheduler with a depth-buffer memory model (1-cycle read latency).
module tb_fb_render_scheduler;

    localparam int N = 19200;
`ifdef FB_RENDER_DEPTH_TEST_EN
    localparam bit DT = 1'b1;
`else
    localparam bit DT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        busy, frame_done, rast_start, rast_ready;
    logic        rast_done = 1'b0;
    logic        rast_valid = 1'b0;
    logic [14:0] rast_addr = '0;
    logic [3:0]  rast_color = '0;
    logic [11:0] rast_depth = '0;
    logic        fb_we, db_we;
    logic [14:0] fb_addr, db_addr, db_rd_addr;
    logic [3:0]  fb_data;
    logic [11:0] db_data;
    logic [11:0] db_rd_data;

    logic [11:0] dmem [0:N-1];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (db_we) dmem[db_addr] <= db_data;
        db_rd_data <= dmem[db_rd_addr];
    end

    fb_render_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .busy        (busy),
        .frame_done  (frame_done),
        .rast_start  (rast_start),
        .rast_done   (rast_done),
        .rast_valid  (rast_valid),
        .rast_ready  (rast_ready),
        .rast_addr   (rast_addr),
        .rast_color  (rast_color),
        .rast_depth  (rast_depth),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .db_we       (db_we),
        .db_addr     (db_addr),
        .db_data     (db_data),
        .db_rd_addr  (db_rd_addr),
        .db_rd_data  (db_rd_data)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic frag(input logic [14:0] a, input logic [3:0] c, input logic [11:0] d);
        rast_valid = 1'b1;
        rast_addr  = a;
        rast_color = c;
        rast_depth = d;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({busy, frame_done, rast_start, rast_ready, fb_we, db_we} !== 6'b0) begin
            $display("FAIL reset_ctl: got %b want 000000", {busy, frame_done, rast_start, rast_ready, fb_we, db_we});
            n_fail++;
        end
        n_checks++;
        if ({fb_addr, db_addr, fb_data, db_data, db_rd_addr} !== 61'b0) begin
            $display("FAIL reset_data: got %h want 0", {fb_addr, db_addr, fb_data, db_data, db_rd_addr});
            n_fail++;
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            $display("FAIL idle_busy: got %b want 0", busy);
            n_fail++;
        end
    endtask

    task automatic test_clear;
        bit bad = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!bad) begin
                n_checks++;
                if ({fb_we, db_we, fb_addr, db_addr, fb_data, db_data, rast_start, busy} !==
                    {1'b1, 1'b1, 15'(i), 15'(i), 4'd0, 12'd4095, 1'b0, 1'b1}) begin
                    $display("FAIL clear_write[%0d]: got we=%b%b addr=%0d/%0d data=%0d/%0d rs=%b busy=%b want we=11 addr=%0d data=0/4095 rs=0 busy=1",
                             i, fb_we, db_we, fb_addr, db_addr, fb_data, db_data, rast_start, busy, i);
                    n_fail++;
                    bad = 1'b1;
                end
            end
            step();
        end
        n_checks++;
        if ({rast_start, fb_we, db_we, rast_ready} !== 4'b1000) begin
            $display("FAIL rast_start_after_clear: got rs/fbwe/dbwe/rdy=%b want 1000", {rast_start, fb_we, db_we, rast_ready});
            n_fail++;
        end
        step();
        n_checks++;
        if ({rast_start, rast_ready, busy} !== 3'b011) begin
            $display("FAIL raster_entry: got rs/rdy/busy=%b want 011", {rast_start, rast_ready, busy});
            n_fail++;
        end
    endtask

    task automatic test_single;
        frag(15'd5, 4'd3, 12'd100);
        n_checks++;
        if (db_rd_addr !== (DT ? 15'd5 : 15'd0)) begin
            $display("FAIL single_rd_addr: got %0d want %0d", db_rd_addr, DT ? 5 : 0);
            n_fail++;
        end
        n_checks++;
        if (fb_we !== 1'b0) begin
            $display("FAIL single_no_early_write: got fb_we=%b want 0", fb_we);
            n_fail++;
        end
        step();
        rast_valid = 1'b0;
        n_checks++;
        if ({fb_we, db_we, fb_addr, db_addr, fb_data, db_data} !== {1'b1, 1'b1, 15'd5, 15'd5, 4'd3, 12'd100}) begin
            $display("FAIL single_write: got we=%b%b addr=%0d/%0d data=%0d/%0d want we=11 addr=5/5 data=3/100",
                     fb_we, db_we, fb_addr, db_addr, fb_data, db_data);
            n_fail++;
        end
        step();
        n_checks++;
        if ({fb_we, db_we, fb_addr, db_rd_addr} !== 32'b0) begin
            $display("FAIL single_idle_after: got we=%b%b addr=%0d rd=%0d want 0", fb_we, db_we, fb_addr, db_rd_addr);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back;
        frag(15'd7, 4'd1, 12'd200);
        step();
        frag(15'd7, 4'd2, 12'd150);
        n_checks++;
        if ({fb_we, fb_addr, fb_data, db_data} !== {1'b1, 15'd7, 4'd1, 12'd200}) begin
            $display("FAIL b2b_first: got we=%b addr=%0d data=%0d/%0d want 1 7 1/200", fb_we, fb_addr, fb_data, db_data);
            n_fail++;
        end
        step();
        frag(15'd7, 4'd4, 12'd180);
        n_checks++;
        if ({fb_we, fb_addr, fb_data, db_data} !== {1'b1, 15'd7, 4'd2, 12'd150}) begin
            $display("FAIL b2b_second: got we=%b addr=%0d data=%0d/%0d want 1 7 2/150", fb_we, fb_addr, fb_data, db_data);
            n_fail++;
        end
        step();
        rast_valid = 1'b0;
        n_checks++;
        if (DT ? ({fb_we, db_we} !== 2'b00)
               : ({fb_we, db_we, fb_addr, fb_data, db_data} !== {2'b11, 15'd7, 4'd4, 12'd180})) begin
            $display("FAIL b2b_forwarded: got we=%b%b addr=%0d data=%0d/%0d want we=%0d", fb_we, db_we, fb_addr, fb_data, db_data, DT ? 0 : 3);
            n_fail++;
        end
        step();
    endtask

    task automatic test_equal_depth;
        frag(15'd5, 4'd6, 12'd100);
        step();
        rast_valid = 1'b0;
        n_checks++;
        if (DT ? (fb_we !== 1'b0)
               : ({fb_we, db_we, fb_addr, fb_data, db_data} !== {2'b11, 15'd5, 4'd6, 12'd100})) begin
            $display("FAIL equal_depth: got we=%b addr=%0d data=%0d/%0d want we=%b", fb_we, fb_addr, fb_data, db_data, !DT);
            n_fail++;
        end
        step();
        frag(15'd5, 4'd9, 12'd99);
        step();
        rast_valid = 1'b0;
        n_checks++;
        if ({fb_we, db_we, fb_addr, fb_data, db_data} !== {2'b11, 15'd5, 4'd9, 12'd99}) begin
            $display("FAIL less_by_one: got we=%b%b addr=%0d data=%0d/%0d want 11 5 9/99", fb_we, db_we, fb_addr, fb_data, db_data);
            n_fail++;
        end
        step();
    endtask

    task automatic test_done_pending;
        frame_start = 1'b1;
        rast_done   = 1'b1;
        frag(15'd9, 4'd5, 12'd10);
        step();
        frame_start = 1'b0;
        rast_valid  = 1'b0;
        n_checks++;
        if ({fb_we, fb_addr, fb_data, db_data, frame_done, busy} !== {1'b1, 15'd9, 4'd5, 12'd10, 1'b0, 1'b1}) begin
            $display("FAIL done_final_write: got we=%b addr=%0d data=%0d/%0d fd=%b busy=%b want 1 9 5/10 0 1",
                     fb_we, fb_addr, fb_data, db_data, frame_done, busy);
            n_fail++;
        end
        step();
        n_checks++;
        if ({frame_done, busy, fb_we, rast_ready} !== 4'b1100) begin
            $display("FAIL drain_pulse: got fd/busy/we/rdy=%b want 1100", {frame_done, busy, fb_we, rast_ready});
            n_fail++;
        end
        rast_done = 1'b0;
        step();
        n_checks++;
        if ({frame_done, busy} !== 2'b00) begin
            $display("FAIL done_to_idle: got fd/busy=%b want 00", {frame_done, busy});
            n_fail++;
        end
        step();
        n_checks++;
        if ({frame_done, busy, fb_we} !== 3'b000) begin
            $display("FAIL idle_hold: got fd/busy/we=%b want 000 (ignored frame_start)", {frame_done, busy, fb_we});
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_clear;
        bit seen = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        repeat (500) step();
        n_checks++;
        if ({fb_we, fb_addr} !== {1'b1, 15'd500}) begin
            $display("FAIL mid_clear_addr: got we=%b addr=%0d want 1 500", fb_we, fb_addr);
            n_fail++;
        end
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({busy, frame_done, rast_start, rast_ready, fb_we, db_we, fb_addr, db_addr, fb_data, db_data, db_rd_addr} !== 67'b0) begin
            $display("FAIL reset_mid_clear: got busy=%b we=%b%b addr=%0d data=%0d/%0d want all 0",
                     busy, fb_we, db_we, fb_addr, fb_data, db_data);
            n_fail++;
        end
        rst_n       = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        n_checks++;
        if ({fb_we, fb_addr, busy} !== {1'b1, 15'd0, 1'b1}) begin
            $display("FAIL restart_clear: got we=%b addr=%0d busy=%b want 1 0 1", fb_we, fb_addr, busy);
            n_fail++;
        end
        step();
        n_checks++;
        if ({fb_we, fb_addr} !== {1'b1, 15'd1}) begin
            $display("FAIL restart_clear_next: got we=%b addr=%0d want 1 1", fb_we, fb_addr);
            n_fail++;
        end
        for (int i = 0; i < N + 10; i++) begin
            if (!seen) begin
                if (rast_ready === 1'b1) seen = 1'b1;
                else step();
            end
        end
        n_checks++;
        if (!seen) begin
            $display("FAIL raster_timeout: got rast_ready=%b want 1 within %0d cycles", rast_ready, N + 10);
            n_fail++;
        end
        frag(15'd11, 4'd2, 12'd1);
        rst_n = 1'b0;
        step();
        rast_valid = 1'b0;
        n_checks++;
        if ({busy, rast_ready, fb_we, db_we, fb_addr, db_rd_addr} !== 34'b0) begin
            $display("FAIL reset_mid_raster: got busy=%b rdy=%b we=%b%b addr=%0d rd=%0d want all 0",
                     busy, rast_ready, fb_we, db_we, fb_addr, db_rd_addr);
            n_fail++;
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({busy, fb_we} !== 2'b00) begin
            $display("FAIL after_reset_raster: got busy/we=%b want 00 (pending discarded)", {busy, fb_we});
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_single();
        test_back_to_back();
        test_equal_depth();
        test_done_pending();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_render_scheduler.md
FB_RENDER_SCHEDULER -- requirements
Module: fb_render_scheduler

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 160, framebuffer width in pixels.
REQ-002 SHALL have parameter FB_HEIGHT, default 120, framebuffer height in pixels.
REQ-003 SHALL have parameter FB_DATAW, default 4, colour index bits; parameter DB_DATAW, default 12, depth bits.
REQ-004 SHALL have parameters FB_CLEAR_VALUE, default 0, and DB_CLEAR_VALUE, default 4095, the per-frame clear values.
REQ-005 SHALL derive FB_ADDRW = $clog2(FB_WIDTH*FB_HEIGHT).
REQ-006 SHALL have ports, in this order: clk input 1 (the single clock); rst_n input 1 (synchronous, active-low reset).
REQ-007 SHALL have: frame_start input 1, start-of-frame pulse; busy output 1; frame_done output 1, one-cycle pulse.
REQ-008 SHALL have: rast_start output 1, one-cycle pulse; rast_done input 1, level.
REQ-009 SHALL have: rast_valid input 1; rast_ready output 1; rast_addr input FB_ADDRW; rast_color input FB_DATAW; rast_depth input DB_DATAW.
REQ-010 SHALL have: fb_we output 1; fb_addr output FB_ADDRW; fb_data output FB_DATAW.
REQ-011 SHALL have: db_we output 1; db_addr output FB_ADDRW; db_data output DB_DATAW.
REQ-012 SHALL have: db_rd_addr output FB_ADDRW; db_rd_data input DB_DATAW, valid exactly 1 cycle after db_rd_addr.

Function
REQ-013 SHALL implement the FSM IDLE -> CLEAR -> START -> RASTER -> DRAIN -> IDLE.
REQ-014 IDLE: frame_start=1 SHALL move to CLEAR with the clear counter at 0; frame_start in any other state SHALL be ignored.
REQ-015 CLEAR: each cycle SHALL assert fb_we and db_we at addr = counter with FB_CLEAR_VALUE/DB_CLEAR_VALUE, and increment the counter.
REQ-016 CLEAR: after address FB_WIDTH*FB_HEIGHT-1 is written, SHALL go to START; the clear takes exactly FB_WIDTH*FB_HEIGHT cycles.
REQ-017 START: SHALL pulse rast_start for one cycle, then go to RASTER.
REQ-018 rast_ready SHALL be 1 only in RASTER; a fragment is accepted when rast_valid && rast_ready.
REQ-019 Each accepted fragment SHALL drive db_rd_addr=rast_addr in the accept cycle, then be evaluated in the following cycle.
REQ-020 Evaluation: if rast_depth < stored depth, SHALL assert fb_we/db_we at that address with rast_color/rast_depth (write 1 cycle after accept); otherwise write nothing.
REQ-021 Stored depth SHALL be forwarded from the in-flight write when the previous accepted fragment wrote the same address (back-to-back hazard).
REQ-022 Throughput SHALL be one fragment per cycle in RASTER.
REQ-023 RASTER: rast_done=1 with no accept in that cycle SHALL move to DRAIN; DRAIN completes the pending evaluation, pulses frame_done, and returns to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 fb_we/db_we SHALL never assert outside CLEAR and the evaluation cycle; fb_addr equals db_addr whenever either enable is set.
REQ-026 Depth comparison SHALL be unsigned DB_DATAW-bit; equal depth SHALL NOT write.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE, counter 0, and all outputs 0 (pending evaluation discarded), including mid-CLEAR and mid-RASTER.
REQ-028 The first frame_start SHALL be honoured on the first cycle after rst_n returns to 1.

Configuration
REQ-029 With macro FB_RENDER_DEPTH_TEST_EN defined, REQ-019..REQ-021 and REQ-026 SHALL apply.
REQ-030 Without it, every accepted fragment SHALL be written one cycle after accept with no comparison; db_rd_addr SHALL be held 0; db_we/db_data still write rast_depth.

Structure
REQ-031 The state enum and the clear-value defaults SHALL live in shared package render_pkg.
REQ-032 Compare, forward and write-issue SHALL live in sub-module depth_test_pipe; the FSM and clear counter stay in the top level.

Verification
REQ-033 Reset, frame_start -> 19200 consecutive writes addr 0..19199, fb_data=0, db_data=4095, then rast_start exactly 1 cycle later.
REQ-034 Fragment addr 5, depth 100, colour 3 after clear -> fb_we/db_we at addr 5, data 3/100, 1 cycle after accept.
REQ-035 Back-to-back addr 7: depth 200 then 150 -> both write; then 180 -> no write (forwarded 150).
REQ-036 Equal depth 100 on addr 5 after REQ-034 -> no write; with FB_RENDER_DEPTH_TEST_EN undefined -> write.
REQ-037 rst_n=0 at clear address 500 -> next cycle all outputs 0, IDLE; a new frame_start restarts the clear at addr 0.
REQ-038 rast_done with a fragment still pending -> final write issued, frame_done 1-cycle pulse, busy falls, frame_start during RASTER ignored.
